// File: rtl/io_button_pkg.sv
// Shared register offsets, field widths and helpers for the push-button controller.
// Imported by the per-channel debouncer and the memory-mapped top level.
package io_button_pkg;

    localparam logic [2:0] REG_LEVEL    = 3'd0;
    localparam logic [2:0] REG_EVENT    = 3'd1;
    localparam logic [2:0] REG_IRQ_MASK = 3'd2;
    localparam logic [2:0] REG_CTRL     = 3'd3;
    localparam logic [2:0] REG_PRESS0   = 3'd4;

    localparam int PRESS_CNT_W = 8;
    localparam int CTRL_EN_BIT = 0;
    localparam int MAX_CH      = 4;

    // A clear and a press landing on the same edge leave the count at 1.
    function automatic logic [PRESS_CNT_W-1:0] press_cnt_next(
        input logic [PRESS_CNT_W-1:0] cnt,
        input logic                   clr,
        input logic                   press
    );
        logic [PRESS_CNT_W-1:0] base;
        base = clr ? '0 : cnt;
        if (press && (base != '1)) begin
            base = base + 1'b1;
        end
        return base;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, mismatch counter and debounced level.
// rise pulses for the cycle whose closing edge makes the debounced level go high.
module btn_debounce
    import io_button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    // The counter stops at DEBOUNCE_CYC-1: that edge either accepts or sees the match and clears.
    always_comb begin
        accept   = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
        stable_d = accept ? sync2_q : stable_q;
        cnt_d    = cnt_q + 1'b1;
        if ((sync2_q == stable_q) || accept) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    assign rise  = accept && sync2_q;

endmodule

// File: rtl/io_button_ctrl.sv
// Memory-mapped multi-channel push-button controller: debounced levels, sticky press
// events, saturating press counters, maskable interrupt and a registered read port.
module io_button_ctrl
    import io_button_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          DEBOUNCE_CYC = 250000,
    parameter logic [11:0] BASE_ADDR    = 12'hFF0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_raw,
    input  logic [11:0]       addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] level,
    output logic              irq
);

    logic                   sel;
    logic [2:0]             off;
    logic                   wr_hit;
    logic                   rd_hit;
    logic [NUM_CH-1:0]      rise;
    logic [NUM_CH-1:0]      ev_clear;
    logic [NUM_CH-1:0]      event_q;
    logic [NUM_CH-1:0]      event_d;
    logic [NUM_CH-1:0]      mask_q;
    logic [NUM_CH-1:0]      mask_d;
    logic                   en_q;
    logic                   en_d;
    logic [PRESS_CNT_W-1:0] press_cnt_q [NUM_CH];
    logic [PRESS_CNT_W-1:0] press_cnt_d [NUM_CH];
    logic [PRESS_CNT_W-1:0] press_rd    [MAX_CH];
    logic [31:0]            reg_val;
    logic [31:0]            rdata_q;
    logic [31:0]            rdata_d;
    logic                   irq_q;
    logic                   irq_d;
    logic                   unused_wdata;

    assign sel    = (addr[11:3] == BASE_ADDR[11:3]);
    assign off    = addr[2:0];
    assign wr_hit = wr_en && sel;
    assign rd_hit = rd_en && sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            btn_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_debounce (
                .clock(clock),
                .reset(reset),
                .raw  (btn_raw[gi]),
                .level(level[gi]),
                .rise (rise[gi])
            );
        end

        // Counter slots past NUM_CH read back as zero.
        for (gi = 0; gi < MAX_CH; gi++) begin : g_press_rd
            if (gi < NUM_CH) begin : g_used
                assign press_rd[gi] = press_cnt_q[gi];
            end else begin : g_empty
                assign press_rd[gi] = '0;
            end
        end
    endgenerate

    // Set beats W1C: the clear is applied first, then the new press is ORed in.
    always_comb begin
        ev_clear = (wr_hit && (off == REG_EVENT)) ? wdata[NUM_CH-1:0] : '0;
        event_d  = event_q & ~ev_clear;
        if (en_q) begin
            event_d = event_d | rise;
        end
        mask_d = (wr_hit && (off == REG_IRQ_MASK)) ? wdata[NUM_CH-1:0] : mask_q;
        en_d   = (wr_hit && (off == REG_CTRL)) ? wdata[CTRL_EN_BIT] : en_q;
        for (int i = 0; i < NUM_CH; i++) begin
            press_cnt_d[i] = press_cnt_next(press_cnt_q[i],
                                            wr_hit && (off == (REG_PRESS0 + 3'(i))),
                                            en_q && rise[i]);
        end
    end

    always_comb begin
        reg_val = '0;
        case (off)
            REG_LEVEL:    reg_val = 32'(level);
            REG_EVENT:    reg_val = 32'(event_q);
            REG_IRQ_MASK: reg_val = 32'(mask_q);
            REG_CTRL:     reg_val[CTRL_EN_BIT] = en_q;
            default:      reg_val = 32'(press_rd[off[1:0]]);
        endcase
        rdata_d = rd_hit ? reg_val : '0;
        irq_d   = |(event_q & mask_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            event_q <= '0;
            mask_q  <= '0;
            en_q    <= 1'b1;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                press_cnt_q[i] <= '0;
            end
        end else begin
            event_q <= event_d;
            mask_q  <= mask_d;
            en_q    <= en_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            for (int i = 0; i < NUM_CH; i++) begin
                press_cnt_q[i] <= press_cnt_d[i];
            end
        end
    end

    assign rdata        = rdata_q;
    assign irq          = irq_q;
    assign unused_wdata = ^wdata[31:NUM_CH];

endmodule

// File: tb/tb_io_button_ctrl.sv
// Directed and randomized checks of io_button_ctrl against a window-based behavioural model.
module tb_io_button_ctrl;

    localparam int          DC   = 4;
    localparam int          NCH  = 4;
    localparam logic [11:0] BASE = 12'hFF0;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [3:0]  btn_raw = 4'h0;
    logic [11:0] addr    = 12'h0;
    logic        rd_en   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [31:0] wdata   = 32'h0;
    logic [31:0] rdata;
    logic [3:0]  level;
    logic        irq;

    int tests = 0;
    int fails = 0;

    // Model state: raw_log keeps the raw vector sampled at recent edges.
    logic [3:0]  m_level;
    logic [3:0]  m_event;
    logic [3:0]  m_mask;
    logic        m_en;
    logic [7:0]  m_cnt [4];
    logic [31:0] m_rdata;
    logic        m_irq;
    logic [3:0]  raw_log [$];

    io_button_ctrl #(
        .NUM_CH      (NCH),
        .DEBOUNCE_CYC(DC),
        .BASE_ADDR   (BASE)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .btn_raw(btn_raw),
        .addr   (addr),
        .rd_en  (rd_en),
        .wr_en  (wr_en),
        .wdata  (wdata),
        .rdata  (rdata),
        .level  (level),
        .irq    (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = '0;
        m_event = '0;
        m_mask  = '0;
        m_en    = 1'b1;
        m_rdata = '0;
        m_irq   = 1'b0;
        for (int c = 0; c < 4; c++) m_cnt[c] = '0;
        raw_log.delete();
        for (int k = 0; k < DC + 2; k++) raw_log.push_back(4'h0);
    endtask

    function automatic logic [31:0] model_reg(input logic [2:0] o);
        case (o)
            3'd0:    return 32'(m_level);
            3'd1:    return 32'(m_event);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_en);
            default: return 32'(m_cnt[o - 3'd4]);
        endcase
    endfunction

    // A level is accepted once the synchronised input (raw two edges late) has
    // shown the opposite value for DC consecutive edges.
    task automatic model_edge();
        logic        sel;
        logic [2:0]  o;
        logic [3:0]  rise;
        logic [3:0]  nl;
        logic [31:0] rd_next;
        logic        irq_next;
        logic        v;
        logic        steady;
        int          n;
        if (!reset) begin
            model_reset();
            return;
        end
        sel      = (addr[11:3] == BASE[11:3]);
        o        = addr[2:0];
        rd_next  = (rd_en && sel) ? model_reg(o) : 32'h0;
        irq_next = |(m_event & m_mask);
        rise     = '0;
        nl       = m_level;
        n        = raw_log.size();
        for (int c = 0; c < NCH; c++) begin
            v      = raw_log[n-2][c];
            steady = 1'b1;
            for (int k = 0; k < DC; k++) begin
                if (raw_log[n-2-k][c] != v) steady = 1'b0;
            end
            if (steady && (v != m_level[c])) begin
                nl[c]   = v;
                rise[c] = v;
            end
        end
        if (wr_en && sel && o == 3'd1) m_event = m_event & ~wdata[3:0];
        if (m_en) m_event = m_event | rise;
        for (int c = 0; c < NCH; c++) begin
            if (wr_en && sel && (int'(o) == 4 + c)) m_cnt[c] = 8'h00;
            if (m_en && rise[c] && m_cnt[c] != 8'hFF) m_cnt[c] = m_cnt[c] + 8'h01;
        end
        if (wr_en && sel && o == 3'd2) m_mask = wdata[3:0];
        if (wr_en && sel && o == 3'd3) m_en = wdata[0];
        m_level = nl;
        m_rdata = rd_next;
        m_irq   = irq_next;
        raw_log.push_back(btn_raw);
        if (raw_log.size() > DC + 2) void'(raw_log.pop_front());
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("level", 32'(level), 32'(m_level));
        check("irq", 32'(irq), 32'(m_irq));
        check("rdata", rdata, m_rdata);
    endtask

    task automatic rd(input logic [11:0] a);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        $display("[TB] RD  addr=%h data=%h", a, rdata);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        $display("[TB] WR  addr=%h data=%h", a, d);
    endtask

    task automatic settle();
        repeat (DC + 4) tick();
    endtask

    initial begin
        int          edges;
        logic [3:0]  ev_snap;
        logic [7:0]  cnt_snap;
        logic [2:0]  o;
        int          op;

        // 1: reset held with all buttons asserted
        reset   = 1'b0;
        btn_raw = 4'hF;
        model_reset();
        repeat (3) tick();
        check("rst_level", 32'(level), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        btn_raw = 4'h0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        rd(BASE + 12'd3);
        check("ctrl_after_reset", rdata, 32'h1);

        // 2: raw-to-level latency
        btn_raw[0] = 1'b1;
        edges = 0;
        while (!level[0] && edges < 20) begin
            tick();
            edges++;
        end
        check("latency_ch0", 32'(edges), 32'(2 + DC));
        rd(BASE + 12'd1);
        check("event_after_press", rdata, 32'h1);
        rd(BASE + 12'd4);
        check("press_cnt0", rdata, 32'h1);

        // 3: short glitch is filtered
        btn_raw[1] = 1'b1;
        repeat (3) tick();
        btn_raw[1] = 1'b0;
        repeat (8) tick();
        check("glitch_level1", 32'(level[1]), 32'h0);
        rd(BASE + 12'd1);
        check("glitch_event1", 32'(rdata[1]), 32'h0);
        rd(BASE + 12'd5);
        check("glitch_cnt1", rdata, 32'h0);

        // 4: irq follows EVENT & MASK one cycle later, and W1C drops it
        wr(BASE + 12'd1, 32'hF);
        btn_raw[0] = 1'b0;
        settle();
        wr(BASE + 12'd2, 32'h1);
        btn_raw[0] = 1'b1;
        edges = 0;
        while (!level[0] && edges < 20) begin
            tick();
            edges++;
        end
        check("irq_same_edge", 32'(irq), 32'h0);
        tick();
        check("irq_rise", 32'(irq), 32'h1);
        wr(BASE + 12'd1, 32'h1);
        check("irq_hold", 32'(irq), 32'h1);
        tick();
        check("irq_drop", 32'(irq), 32'h0);
        rd(BASE + 12'd1);
        check("event_cleared", rdata, 32'h0);

        // 5: W1C colliding with a press keeps the flag set
        btn_raw[2] = 1'b1;
        repeat (2 + DC - 1) tick();
        wr(BASE + 12'd1, 32'h4);
        check("collide_level2", 32'(level[2]), 32'h1);
        rd(BASE + 12'd1);
        check("collide_event2", 32'(rdata[2]), 32'h1);

        for (int p = 0; p < 300; p++) begin
            btn_raw[3] = 1'b1;
            repeat (DC + 3) tick();
            btn_raw[3] = 1'b0;
            repeat (DC + 3) tick();
        end
        rd(BASE + 12'd7);
        check("press_cnt3_sat", rdata, 32'hFF);
        wr(BASE + 12'd7, 32'h0);
        rd(BASE + 12'd7);
        check("press_cnt3_clr", rdata, 32'h0);
        btn_raw[3] = 1'b1;
        repeat (2 + DC - 1) tick();
        wr(BASE + 12'd7, 32'h0);
        rd(BASE + 12'd7);
        check("press_clr_collide", rdata, 32'h1);

        // 6: disabled presses freeze EVENT/PRESS_CNT but not level
        wr(BASE + 12'd3, 32'h0);
        btn_raw[0] = 1'b0;
        settle();
        ev_snap  = m_event;
        cnt_snap = m_cnt[0];
        btn_raw[0] = 1'b1;
        settle();
        check("freeze_level0", 32'(level[0]), 32'h1);
        rd(BASE + 12'd1);
        check("freeze_event", rdata, 32'(ev_snap));
        rd(BASE + 12'd4);
        check("freeze_cnt0", rdata, 32'(cnt_snap));

        // Reset in the middle of a debounce count and a read
        btn_raw = 4'h2;
        repeat (3) tick();
        rd(BASE + 12'd3);
        reset = 1'b0;
        #1;
        model_reset();
        check("midrst_level", 32'(level), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        repeat (3) tick();
        reset = 1'b1;
        edges = 0;
        while (!level[1] && edges < 20) begin
            tick();
            edges++;
        end
        check("latency_after_reset", 32'(edges), 32'(2 + DC));
        rd(BASE + 12'd3);
        check("ctrl_en_restored", rdata, 32'h1);

        // Randomized traffic: bouncing buttons plus random register accesses
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
            end
            op = int'($urandom_range(0, 5));
            o  = 3'($urandom_range(0, 7));
            addr  = ($urandom_range(0, 7) == 0) ? (12'hFE0 + 12'(o)) : (BASE + 12'(o));
            wdata = $urandom;
            rd_en = (op == 1 || op == 3);
            wr_en = (op == 2 || op == 3);
            tick();
            if (rd_en || wr_en) begin
                $display("[TB] RND addr=%h rd=%0d wr=%0d wdata=%h rdata=%h",
                         addr, rd_en, wr_en, wdata, rdata);
            end
            rd_en = 1'b0;
            wr_en = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
